dsram_port_arb: RTL and testbench
=================================

# dsram_port_arb

Arbiter and store queue for the single data-SRAM port. Loads issued by the AGU in EX use the port in the same cycle. Committed stores are buffered in a small FIFO and drained into the SRAM when the port is idle. Forced drains on queue-full or starvation bound store latency. The block sits between the AGU / commit logic and the data SRAM (or D-cache front end).

## Interface
Parameters:
- `DEPTH`, 4 — store-queue entries; power of two, ≥2
- `STARVE_MAX`, 8 — consecutive cycles a non-empty queue may be blocked by loads before a forced drain; ≥1

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `load_req`  in  1  AGU load wants the port this cycle
- `load_addr`  in  32  load byte address
- `load_stall`  out  1  load not granted this cycle; AGU holds `load_req` and `load_addr`
- `st_push`  in  1  commit retires one store
- `st_addr`  in  32  store address
- `st_sel`  in  4  byte-lane strobe; nonzero on push
- `st_data`  in  32  lane-replicated store data
- `st_full`  out  1  count == DEPTH
- `st_empty`  out  1  count == 0
- `st_count`  out  $clog2(DEPTH)+1  valid entries
- `data_sram_en`  out  1  port access this cycle
- `data_sram_wen`  out  4  write strobe; 0 for loads
- `data_sram_addr`  out  32  access address
- `data_sram_wdata`  out  32  write data

## Operation
- FSM states:
  - IDLE: queue empty.
  - SHARE: non-empty; loads have priority.
  - FORCE: the head entry drains regardless of `load_req`.
- Transitions:
  - IDLE→SHARE on push.
  - SHARE→FORCE when either:
    - the queue will be full next cycle, or
    - the starve counter reaches STARVE_MAX−1 while blocked.
  - FORCE→SHARE (or →IDLE if the queue empties) after exactly one drain.
  - SHARE→IDLE when the last entry drains and there is no push.
- Port grant, combinational each cycle, in priority order:
  1. Drain when state is FORCE, or when `st_full` is 1.
  2. Otherwise grant the load if `load_req` is 1.
  3. Otherwise drain if the queue is non-empty.
  4. Otherwise the port is idle.
- Load grant drives `data_sram_en`=1, `wen`=0, `addr`=`load_addr`, `wdata`=0.
- Drain drives `en`=1, `wen`=head `st_sel`, `addr`=head `st_addr`, `wdata`=head `st_data`, then pops the head.
- `load_stall` = `load_req` & ~load granted.
- Starve counter:
  - Increments each cycle the queue is non-empty and no drain occurs.
  - Clears on any drain or when the queue is empty.
  - Saturates at STARVE_MAX.
- Push and pop in the same cycle: both take effect and count is unchanged.
- Push when full: accepted, because full always forces a drain in the same cycle.
- An entry pushed into an empty queue drains no earlier than the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo DEPTH. Count is a separate register.

## Timing
- Load grant and SRAM request are combinational, in the same cycle as `load_req`. The arbiter adds zero latency.
- Minimum store latency is push at cycle N → SRAM write at cycle N+1.
- Maximum store latency with an unbroken load stream is STARVE_MAX+1 cycles per entry ahead of it.
- `st_full`, `st_empty`, `st_count` are registered-state derived and are valid from the cycle after the push or pop.
- Reset (asynchronous, any time, including mid-drain or mid-FORCE):
  - Queue empties; state IDLE; starve counter 0.
  - `st_empty`=1; `st_full`=0; `st_count`=0.
  - While `reset` is high: `data_sram_en`=0, `wen`=0, `addr`=0, `wdata`=0, `load_stall`=0.
  - Queued stores are discarded.

## Configuration
- `DSRAM_STQ_HAZARD_EN` defined:
  - A load whose `load_addr[31:2]` equals `st_addr[31:2]` of any valid entry is not granted, and `load_stall`=1.
  - The FSM enters FORCE until no matching entry remains.
  - This gives read-after-write ordering through the queue.
- Not defined:
  - There is no address comparison.
  - The pipeline guarantees a load never hits a queued store (for example via a sync on `st_empty`).

## Structure
- Shared defines header holds:
  - FSM state encodings (IDLE/SHARE/FORCE, 2 bits).
  - `STQ_ENTRY_WD` = 68 (addr 32 + sel 4 + data 32).
  - Field-slice macros for addr/sel/data within an entry.
- Sub-module `stq_fifo` holds entry storage, read/write pointers, count, and full/empty. It exposes head entry and per-entry valid/addr for the hazard compare.
- The top level contains the FSM, starve counter, grant mux and hazard compare.

## Test plan
- Reset then single push (addr 0x100, sel 0xF, data 0xDEADBEEF), no loads → next cycle `en`=1, `wen`=0xF, addr 0x100; `st_empty`=1 after.
- Continuous `load_req` with 1 queued store, STARVE_MAX=8 → loads granted 8 cycles. Cycle 9 is a forced drain with `load_stall`=1. Loads resume on cycle 10.
- Fill DEPTH=4 entries under continuous loads → `st_full`=1 forces a drain. A 5th push in that cycle is accepted and `st_count` stays 4.
- Simultaneous push and drain for 10 cycles → `st_count` constant and pointers wrap. Drain order matches push order.
- With `DSRAM_STQ_HAZARD_EN`, load 0x104 while an entry at 0x106 is queued → `load_stall`=1 until that entry writes, then the load is granted the following cycle. Without the macro, the load is granted immediately.
- Assert `reset` during a FORCE drain → all SRAM outputs 0 immediately, queue empty, and no write after deassert.

Source files
------------

// File: rtl/dsram_port_arb_pkg.sv
// rtl/dsram_port_arb_pkg.sv - shared encodings and entry layout for the data-SRAM port arbiter
package dsram_port_arb_pkg;

    // Arbiter FSM encodings
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_SHARE = 2'd1;
    localparam logic [1:0] STATE_FORCE = 2'd2;

    // Store-queue entry layout: {addr, sel, data}
    localparam int STQ_ENTRY_WD = 68;
    localparam int STQ_DATA_LSB = 0;
    localparam int STQ_SEL_LSB  = 32;
    localparam int STQ_ADDR_LSB = 36;

    typedef logic [STQ_ENTRY_WD-1:0] stq_entry_t;

    function automatic stq_entry_t stq_pack(input logic [31:0] addr, input logic [3:0] sel,
                                            input logic [31:0] data);
        return {addr, sel, data};
    endfunction

    function automatic logic [31:0] stq_addr(input stq_entry_t e);
        return e[STQ_ADDR_LSB +: 32];
    endfunction

    function automatic logic [3:0] stq_sel(input stq_entry_t e);
        return e[STQ_SEL_LSB +: 4];
    endfunction

    function automatic logic [31:0] stq_data(input stq_entry_t e);
        return e[STQ_DATA_LSB +: 32];
    endfunction

endpackage

// File: rtl/dsram_port_arb_stq_fifo.sv
// rtl/dsram_port_arb_stq_fifo.sv - committed-store FIFO with per-entry address visibility
module dsram_port_arb_stq_fifo
    import dsram_port_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  stq_entry_t                  push_entry,
    input  logic                        pop,
    output stq_entry_t                  head_entry,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][31:0]      ent_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stq_entry_t      mem_q [DEPTH];
    stq_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   off;

    // Next-state for storage, pointers and count; a push while full lands in the slot being popped
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (push) mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Head and per-entry valid/address view used by the hazard compare
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, off} < count_q);
            ent_addr[i]  = stq_addr(mem_q[i]);
        end
        head_entry = mem_q[rd_ptr_q];
        count      = count_q;
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
    end

    // State registers; reset discards all queued stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dsram_port_arb.sv
// rtl/dsram_port_arb.sv - data-SRAM port arbiter and store queue; DSRAM_STQ_HAZARD_EN enables load/store address hazard stall
module dsram_port_arb
    import dsram_port_arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_req,
    input  logic [31:0]             load_addr,
    output logic                    load_stall,
    input  logic                    st_push,
    input  logic [31:0]             st_addr,
    input  logic [3:0]              st_sel,
    input  logic [31:0]             st_data,
    output logic                    st_full,
    output logic                    st_empty,
    output logic [$clog2(DEPTH):0]  st_count,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]              state_q, state_d;
    logic [SW-1:0]           starve_q, starve_d;
    stq_entry_t              head;
    logic [31:0]             head_addr;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0][31:0]  ent_addr;
    logic                    force_drain, load_gnt, drain, blocked;
    logic                    hazard, hazard_next;
    logic [CW-1:0]           cnt_next;

    assign head_addr = stq_addr(head);

    dsram_port_arb_stq_fifo #(.DEPTH(DEPTH)) u_stq (
        .clk        (clk),
        .reset      (reset),
        .push       (st_push),
        .push_entry (stq_pack(st_addr, st_sel, st_data)),
        .pop        (drain),
        .head_entry (head),
        .count      (st_count),
        .full       (st_full),
        .empty      (st_empty),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr)
    );

`ifdef DSRAM_STQ_HAZARD_EN
    logic [DEPTH-1:0] match;
    logic             head_match;

    // Word-address compare of the load against every valid queued store
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++)
            match[i] = ent_valid[i] && (ent_addr[i][31:2] == load_addr[31:2]);
    end

    assign head_match  = !st_empty && (head_addr[31:2] == load_addr[31:2]);
    assign hazard      = load_req && (|match);
    // A conflict persists only if a matching entry survives this cycle's drain
    assign hazard_next = hazard && ($countones(match) > ((drain && head_match) ? 1 : 0));
`else
    logic unused_hazard_view;
    assign unused_hazard_view = ^{ent_valid, ent_addr};
    assign hazard      = 1'b0;
    assign hazard_next = 1'b0;
`endif

    // Port grant: forced drain, then load, then opportunistic drain; everything quiet in reset
    always_comb begin
        force_drain     = !st_empty && ((state_q == STATE_FORCE) || st_full);
        load_gnt        = !reset && load_req && !force_drain && !hazard;
        drain           = !reset && !st_empty && !load_gnt;
        load_stall      = !reset && load_req && !load_gnt;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (drain) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = stq_sel(head);
            data_sram_addr  = head_addr;
            data_sram_wdata = stq_data(head);
        end else if (load_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_addr  = load_addr;
        end
    end

    // Starve counter: cycles the queue has waited behind loads since its last drain
    always_comb begin
        blocked  = !st_empty && !drain;
        starve_d = starve_q;
        if (st_empty || drain)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    // FSM next state from the post-cycle occupancy and pending starvation/hazard
    always_comb begin
        cnt_next = st_count + CW'(st_push) - CW'(drain);
        state_d  = state_q;
        case (state_q)
            STATE_IDLE: state_d = st_push ? STATE_SHARE : STATE_IDLE;
            default: begin
                if (cnt_next == '0)
                    state_d = STATE_IDLE;
                else if ((cnt_next == CW'(DEPTH)) || hazard_next ||
                         (blocked && (starve_q == SW'(STARVE_MAX - 1))))
                    state_d = STATE_FORCE;
                else
                    state_d = STATE_SHARE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_dsram_port_arb.sv
// tb/tb_dsram_port_arb.sv - randomized self-checking bench for dsram_port_arb against a queue model
module tb_dsram_port_arb;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_req;
    logic [31:0]   load_addr;
    logic          load_stall;
    logic          st_push;
    logic [31:0]   st_addr;
    logic [3:0]    st_sel;
    logic [31:0]   st_data;
    logic          st_full, st_empty;
    logic [CW-1:0] st_count;
    logic          data_sram_en;
    logic [3:0]    data_sram_wen;
    logic [31:0]   data_sram_addr, data_sram_wdata;

    always #5 clk = ~clk;

    dsram_port_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_req        (load_req),
        .load_addr       (load_addr),
        .load_stall      (load_stall),
        .st_push         (st_push),
        .st_addr         (st_addr),
        .st_sel          (st_sel),
        .st_data         (st_data),
        .st_full         (st_full),
        .st_empty        (st_empty),
        .st_count        (st_count),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } st_t;

    st_t mq[$];
    int  mstarve;
    bit  mforced;
    int  checks = 0;
    int  errors = 0;

    logic        obs_en, obs_stall, obs_full, obs_empty;
    logic [3:0]  obs_wen;
    logic [31:0] obs_addr, obs_count;
    logic        stall_log [10];
    int          grants;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: inputs are already driven; sample mid-cycle, compare, advance model, move past next edge
    task automatic step();
        int  n, nm, rem, na;
        bit  haz, fd, lg, dr, blocked, e_en, e_stall;
        st_t h;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
        #2;
        obs_en    = data_sram_en;
        obs_wen   = data_sram_wen;
        obs_addr  = data_sram_addr;
        obs_stall = load_stall;
        obs_full  = st_full;
        obs_empty = st_empty;
        obs_count = 32'(st_count);
        if (reset) begin
            check("rst_en",    32'(data_sram_en),  32'(0));
            check("rst_wen",   32'(data_sram_wen), 32'(0));
            check("rst_addr",  data_sram_addr,     32'(0));
            check("rst_wdata", data_sram_wdata,    32'(0));
            check("rst_stall", 32'(load_stall),    32'(0));
            check("rst_count", 32'(st_count),      32'(0));
            check("rst_empty", 32'(st_empty),      32'(1));
            check("rst_full",  32'(st_full),       32'(0));
            mq.delete();
            mstarve = 0;
            mforced = 0;
        end else begin
            n  = mq.size();
            nm = 0;
`ifdef DSRAM_STQ_HAZARD_EN
            if (load_req)
                foreach (mq[i]) if (mq[i].addr[31:2] == load_addr[31:2]) nm++;
`endif
            haz = (nm > 0);
            fd  = (n > 0) && (mforced || n == DEPTH);
            lg  = load_req && !fd && !haz;
            dr  = (n > 0) && !lg;
            if (n > 0) h = mq[0];
            else h = '{addr: 32'h0, sel: 4'h0, data: 32'h0};
            e_en    = lg || dr;
            e_wen   = dr ? h.sel : 4'h0;
            e_addr  = dr ? h.addr : (lg ? load_addr : 32'h0);
            e_wdata = dr ? h.data : 32'h0;
            e_stall = load_req && !lg;
            check("en",    32'(data_sram_en),  32'(e_en));
            check("wen",   32'(data_sram_wen), 32'(e_wen));
            check("addr",  data_sram_addr,     e_addr);
            check("wdata", data_sram_wdata,    e_wdata);
            check("stall", 32'(load_stall),    32'(e_stall));
            check("count", 32'(st_count),      32'(n));
            check("full",  32'(st_full),       32'(n == DEPTH));
            check("empty", 32'(st_empty),      32'(n == 0));
            blocked = (n > 0) && !dr;
            rem = nm;
            if (dr && nm > 0 && h.addr[31:2] == load_addr[31:2]) rem--;
            if (dr) void'(mq.pop_front());
            na = mq.size() + (st_push ? 1 : 0);
            mforced = (na > 0) && ((na == DEPTH) || (blocked && mstarve == STARVE_MAX - 1) || (rem > 0));
            if (n == 0 || dr) mstarve = 0;
            else if (mstarve < STARVE_MAX) mstarve++;
            if (st_push) mq.push_back('{addr: st_addr, sel: st_sel, data: st_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        st_push = 1'b1;
        st_addr = a;
        st_sel  = s;
        st_data = d;
    endtask

    task automatic drain_out();
        load_req = 1'b0;
        st_push  = 1'b0;
        repeat (DEPTH + 2) step();
    endtask

    initial begin
        reset     = 1'b1;
        load_req  = 1'b1;
        load_addr = 32'h40;
        drive_push(32'h80, 4'h1, 32'h1);
        @(posedge clk);
        #1;
        step();
        step();
        reset    = 1'b0;
        load_req = 1'b0;
        st_push  = 1'b0;
        step();

        // Single store with idle port drains the next cycle
        drive_push(32'h100, 4'hF, 32'hDEADBEEF);
        step();
        st_push = 1'b0;
        step();
        check("t1_en",   32'(obs_en),  32'(1));
        check("t1_wen",  32'(obs_wen), 32'hF);
        check("t1_addr", obs_addr,     32'h100);
        step();
        check("t1_empty", 32'(obs_empty), 32'(1));

        // Starvation: 8 granted loads, forced drain, then loads resume
        drive_push(32'h200, 4'h3, 32'h11223344);
        step();
        st_push   = 1'b0;
        load_req  = 1'b1;
        load_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            step();
            stall_log[i] = obs_stall;
        end
        grants = 0;
        for (int i = 0; i < 8; i++) if (!stall_log[i]) grants++;
        check("t2_grants", 32'(grants),       32'(8));
        check("t2_force",  32'(stall_log[8]), 32'(1));
        check("t2_resume", 32'(stall_log[9]), 32'(0));
        drain_out();

        // Fill under loads; a push while full is accepted and count holds
        load_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'h400 + 32'(i * 4), 4'(i + 1), 32'hA0 + 32'(i));
            step();
        end
        drive_push(32'h410, 4'h8, 32'hA4);
        step();
        check("t3_full",  32'(obs_full), 32'(1));
        check("t3_drain", 32'(obs_wen),  32'h1);
        st_push = 1'b0;
        step();
        check("t3_count", obs_count, 32'(4));
        drain_out();

        // Push and drain together for 10 cycles; occupancy constant, pointers wrap
        load_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_push(32'h500 + 32'(i * 4), 4'h5, 32'hB0 + 32'(i));
            step();
        end
        load_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_push(32'h600 + 32'(i * 4), 4'hC, 32'hC0 + 32'(i));
            step();
            check("t4_count", obs_count, 32'(2));
        end
        drain_out();

        // Load to the same word as a queued store
        drive_push(32'h106, 4'h4, 32'h55);
        step();
        st_push   = 1'b0;
        load_req  = 1'b1;
        load_addr = 32'h104;
        step();
`ifdef DSRAM_STQ_HAZARD_EN
        check("t5_stall", 32'(obs_stall), 32'(1));
        check("t5_write", 32'(obs_wen),   32'h4);
        step();
        check("t5_grant", 32'(obs_stall), 32'(0));
`else
        check("t5_grant", 32'(obs_stall), 32'(0));
        check("t5_addr",  obs_addr,       32'h104);
`endif
        drain_out();

        // Reset asserted in the middle of a forced drain
        drive_push(32'h700, 4'h6, 32'h77);
        step();
        st_push   = 1'b0;
        load_req  = 1'b1;
        load_addr = 32'h800;
        repeat (8) step();
        check("t6_pre_wen", 32'(data_sram_wen), 32'h6);
        #1;
        reset = 1'b1;
        #1;
        check("t6_en",    32'(data_sram_en),  32'(0));
        check("t6_wen",   32'(data_sram_wen), 32'(0));
        check("t6_addr",  data_sram_addr,     32'(0));
        check("t6_wdata", data_sram_wdata,    32'(0));
        check("t6_stall", 32'(load_stall),    32'(0));
        check("t6_empty", 32'(st_empty),      32'(1));
        check("t6_count", 32'(st_count),      32'(0));
        mq.delete();
        mstarve = 0;
        mforced = 0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_nowrite", 32'(obs_en), 32'(0));
        end

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            load_req  = ($urandom_range(0, 9) < 6);
            load_addr = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            st_push   = ($urandom_range(0, 1) == 1);
            st_addr   = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            st_sel    = 4'($urandom_range(1, 15));
            st_data   = $urandom;
            step();
        end
        reset = 1'b0;
        drain_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
